// File: rtl/kfmmc_block_sequencer_if.sv
// ---------------------------------------------------------------------------
// kfmmc_block_sequencer_if
//   Groups the signals between the block sequencer and its two neighbours:
//   the local sector buffer and the byte-level MMC data I/O engine.
//
//   Sector buffer:
//     buffer_address     sequencer -> buffer  byte address
//     buffer_write       sequencer -> buffer  write strobe
//     buffer_write_data  sequencer -> buffer  write data
//     buffer_read_data   buffer -> sequencer  read data, one clock after address
//   Data I/O engine:
//     disable_data_io       sequencer -> engine  force engine idle
//     start_data_io         sequencer -> engine  one-cycle byte transfer request
//     data_io               sequencer -> engine  1 = receive, 0 = send
//     check_data_start_bit  sequencer -> engine  hunt for start bit on this byte
//     clear_data_crc        sequencer -> engine  restart the data CRC
//     transmit_data         sequencer -> engine  byte to send
//     data_io_busy          engine -> sequencer  transfer in progress
//     received_data         engine -> sequencer  last received byte
//     data_crc              engine -> sequencer  running CRC16
//
//   Modports: master = sequencer side, slave = buffer/engine side.
// ---------------------------------------------------------------------------
interface kfmmc_block_sequencer_if #(
    parameter int ADDR_WIDTH = 9
) ();
    logic [ADDR_WIDTH-1:0] buffer_address;
    logic                  buffer_write;
    logic [7:0]            buffer_write_data;
    logic [7:0]            buffer_read_data;
    logic                  disable_data_io;
    logic                  start_data_io;
    logic                  data_io;
    logic                  check_data_start_bit;
    logic                  clear_data_crc;
    logic [7:0]            transmit_data;
    logic                  data_io_busy;
    logic [7:0]            received_data;
    logic [15:0]           data_crc;

    modport master (
        output buffer_address,
        output buffer_write,
        output buffer_write_data,
        input  buffer_read_data,
        output disable_data_io,
        output start_data_io,
        output data_io,
        output check_data_start_bit,
        output clear_data_crc,
        output transmit_data,
        input  data_io_busy,
        input  received_data,
        input  data_crc
    );

    modport slave (
        input  buffer_address,
        input  buffer_write,
        input  buffer_write_data,
        output buffer_read_data,
        input  disable_data_io,
        input  start_data_io,
        input  data_io,
        input  check_data_start_bit,
        input  clear_data_crc,
        input  transmit_data,
        output data_io_busy,
        output received_data,
        output data_crc
    );
endinterface

// File: rtl/kfmmc_block_sequencer.sv
// ---------------------------------------------------------------------------
// kfmmc_block_sequencer
//   Moves one whole MMC data block between the card and a local sector buffer
//   by sequencing the byte-level data I/O engine.
//     Read : BLOCK_BYTES receive transfers (first one hunts for the start
//            bit), then two CRC bytes checked against the running CRC.
//     Write: buffer bytes sent, CRC appended, CRC status token read, then the
//            card busy line polled until it reads 8'hFF.
//   All state updates happen on the falling edge of clock; reset is
//   synchronous and active-high. Every output is a flop.
//
//   Ports:
//     clock, reset           clock (falling edge active) and sync reset
//     start_read/start_write one-cycle operation requests (read wins)
//     abort                  cancel current operation, no done pulse
//     busy                   operation in progress
//     done                   one-cycle pulse at operation end
//     error_code             0 ok, 1 CRC, 2 write rejected, 3 timeout
//     bus                    buffer + data I/O engine signals (master side)
// ---------------------------------------------------------------------------
module kfmmc_block_sequencer #(
    parameter int BLOCK_BYTES     = 512,
    parameter int ADDR_WIDTH      = 9,
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int BUSY_POLL_LIMIT = 4096
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start_read,
    input  logic                    start_write,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              error_code,
    kfmmc_block_sequencer_if.master bus
);

    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int POLL_W = $clog2(BUSY_POLL_LIMIT + 1);

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(BUSY_POLL_LIMIT - 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_CRC     = 2'd1;
    localparam logic [1:0] ERR_REJECT  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_GUARD  = 3'd3,
        S_WAIT   = 3'd4,
        S_STORE  = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        PH_DATA   = 3'd0,
        PH_CRC_HI = 3'd1,
        PH_CRC_LO = 3'd2,
        PH_STATUS = 3'd3,
        PH_POLL   = 3'd4
    } phase_t;

    state_t                state_q, state_d;
    phase_t                phase_q, phase_d;
    logic                  write_q, write_d;
    logic [CNT_W-1:0]      counter_q, counter_d;
    logic [ADDR_WIDTH-1:0] buffer_address_q, buffer_address_d;
    logic [15:0]           crc_q, crc_d;
    logic [7:0]            crc_hi_q, crc_hi_d;
    logic [WD_W-1:0]       watchdog_q, watchdog_d;
    logic [POLL_W-1:0]     poll_q, poll_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            error_code_q, error_code_d;
    logic                  buffer_write_q, buffer_write_d;
    logic [7:0]            buffer_write_data_q, buffer_write_data_d;
    logic                  disable_q, disable_d;
    logic                  start_q, start_d;
    logic                  data_io_q, data_io_d;
    logic                  check_q, check_d;
    logic                  clear_q, clear_d;
    logic [7:0]            transmit_q, transmit_d;
    logic                  abort_hit;

    // Next-state and next-output computation for the block sequencer FSM.
    always_comb begin
        state_d             = state_q;
        phase_d             = phase_q;
        write_d             = write_q;
        counter_d           = counter_q;
        buffer_address_d    = buffer_address_q;
        crc_d               = crc_q;
        crc_hi_d            = crc_hi_q;
        watchdog_d          = watchdog_q;
        poll_d              = poll_q;
        error_code_d        = error_code_q;
        buffer_write_d      = 1'b0;
        buffer_write_data_d = buffer_write_data_q;
        transmit_d          = transmit_q;
        data_io_d           = data_io_q;
        check_d             = 1'b0;
        clear_d             = 1'b0;
        start_d             = 1'b0;
        busy_d              = 1'b0;
        done_d              = 1'b0;
        disable_d           = 1'b0;
        abort_hit           = abort && (state_q != S_IDLE);

        if (abort_hit) begin
            // Abandon the block silently; error_code keeps its last value.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_read || start_write) begin
                        error_code_d     = ERR_OK;
                        counter_d        = {CNT_W{1'b0}};
                        buffer_address_d = {ADDR_WIDTH{1'b0}};
                        phase_d          = PH_DATA;
                        poll_d           = {POLL_W{1'b0}};
                        write_d          = !start_read;
                        state_d          = start_read ? S_ISSUE : S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FETCH: begin
                    // Address was presented on entry; data is valid now.
                    transmit_d = bus.buffer_read_data;
                    state_d    = S_ISSUE;
                end
                S_ISSUE: begin
                    watchdog_d = {WD_W{1'b0}};
                    state_d    = S_GUARD;
                end
                S_GUARD: begin
                    // The engine may not have raised busy yet; skip one look.
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (!bus.data_io_busy) begin
                        state_d = S_STORE;
                        // Strobe is raised here so it is high during STORE,
                        // while the address still points at this byte.
                        if (!write_q && (phase_q == PH_DATA)) begin
                            buffer_write_d      = 1'b1;
                            buffer_write_data_d = bus.received_data;
                        end else begin
                            buffer_write_d = 1'b0;
                        end
                    end else if (watchdog_q == WD_LAST) begin
                        state_d      = S_FINISH;
                        error_code_d = ERR_TIMEOUT;
                    end else begin
                        watchdog_d = watchdog_q + WD_W'(1'b1);
                    end
                end
                S_STORE: begin
                    state_d = S_ISSUE;
                    case (phase_q)
                        PH_DATA: begin
                            if (counter_q == LAST_BYTE) begin
                                crc_d   = bus.data_crc;
                                phase_d = PH_CRC_HI;
                            end else begin
                                counter_d        = counter_q + CNT_W'(1'b1);
                                buffer_address_d = buffer_address_q + ADDR_WIDTH'(1'b1);
                            end
                        end
                        PH_CRC_HI: begin
                            if (!write_q) begin
                                crc_hi_d = bus.received_data;
                            end else begin
                                crc_hi_d = crc_hi_q;
                            end
                            phase_d = PH_CRC_LO;
                        end
                        PH_CRC_LO: begin
                            if (write_q) begin
                                phase_d = PH_STATUS;
                            end else if ({crc_hi_q, bus.received_data} == crc_q) begin
                                state_d      = S_FINISH;
                                error_code_d = ERR_OK;
                            end else begin
                                state_d      = S_FINISH;
                                error_code_d = ERR_CRC;
                            end
                        end
                        PH_STATUS: begin
                            // CRC status token 3'b010 = data accepted.
                            if (bus.received_data[7:5] == 3'b010) begin
                                phase_d = PH_POLL;
                                poll_d  = {POLL_W{1'b0}};
                            end else begin
                                state_d      = S_FINISH;
                                error_code_d = ERR_REJECT;
                            end
                        end
                        PH_POLL: begin
                            if (bus.received_data == 8'hFF) begin
                                state_d      = S_FINISH;
                                error_code_d = ERR_OK;
                            end else if (poll_q == POLL_LAST) begin
                                state_d      = S_FINISH;
                                error_code_d = ERR_TIMEOUT;
                            end else begin
                                poll_d = poll_q + POLL_W'(1'b1);
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                    // Next write data byte needs a buffer read first.
                    if ((state_d == S_ISSUE) && write_q && (phase_d == PH_DATA)) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = state_d;
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FINISH);
        disable_d = abort_hit || (done_d && (error_code_d == ERR_TIMEOUT));

        // Transfer qualifiers are registered so they are valid during ISSUE.
        if (state_d == S_ISSUE) begin
            start_d   = 1'b1;
            data_io_d = !write_d || (phase_d == PH_STATUS) || (phase_d == PH_POLL);
            check_d   = ((!write_d) && (phase_d == PH_DATA) && (counter_d == {CNT_W{1'b0}}))
                        || (phase_d == PH_STATUS);
            clear_d   = (phase_d == PH_DATA) && (counter_d == {CNT_W{1'b0}});
            if (write_d && (phase_d == PH_CRC_HI)) begin
                transmit_d = crc_d[15:8];
            end else if (write_d && (phase_d == PH_CRC_LO)) begin
                transmit_d = crc_d[7:0];
            end else begin
                transmit_d = transmit_d;
            end
        end else begin
            start_d = 1'b0;
            check_d = 1'b0;
            clear_d = 1'b0;
        end
    end

    // State and output registers, updated on the falling edge.
    always_ff @(negedge clock) begin
        if (reset) begin
            state_q             <= S_IDLE;
            phase_q             <= PH_DATA;
            write_q             <= 1'b0;
            counter_q           <= {CNT_W{1'b0}};
            buffer_address_q    <= {ADDR_WIDTH{1'b0}};
            crc_q               <= 16'h0000;
            crc_hi_q            <= 8'h00;
            watchdog_q          <= {WD_W{1'b0}};
            poll_q              <= {POLL_W{1'b0}};
            busy_q              <= 1'b0;
            done_q              <= 1'b0;
            error_code_q        <= ERR_OK;
            buffer_write_q      <= 1'b0;
            buffer_write_data_q <= 8'h00;
            disable_q           <= 1'b0;
            start_q             <= 1'b0;
            data_io_q           <= 1'b1;
            check_q             <= 1'b0;
            clear_q             <= 1'b0;
            transmit_q          <= 8'hFF;
        end else begin
            state_q             <= state_d;
            phase_q             <= phase_d;
            write_q             <= write_d;
            counter_q           <= counter_d;
            buffer_address_q    <= buffer_address_d;
            crc_q               <= crc_d;
            crc_hi_q            <= crc_hi_d;
            watchdog_q          <= watchdog_d;
            poll_q              <= poll_d;
            busy_q              <= busy_d;
            done_q              <= done_d;
            error_code_q        <= error_code_d;
            buffer_write_q      <= buffer_write_d;
            buffer_write_data_q <= buffer_write_data_d;
            disable_q           <= disable_d;
            start_q             <= start_d;
            data_io_q           <= data_io_d;
            check_q             <= check_d;
            clear_q             <= clear_d;
            transmit_q          <= transmit_d;
        end
    end

    assign busy                     = busy_q;
    assign done                     = done_q;
    assign error_code               = error_code_q;
    assign bus.buffer_address       = buffer_address_q;
    assign bus.buffer_write         = buffer_write_q;
    assign bus.buffer_write_data    = buffer_write_data_q;
    assign bus.disable_data_io      = disable_q;
    assign bus.start_data_io        = start_q;
    assign bus.data_io              = data_io_q;
    assign bus.check_data_start_bit = check_q;
    assign bus.clear_data_crc       = clear_q;
    assign bus.transmit_data        = transmit_q;

endmodule

// File: tb/tb_kfmmc_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_kfmmc_block_sequencer
//   Directed bench: a small engine/buffer model answers transfers from
//   per-test response tables; results are compared with hand-computed values.
//   DUT updates on the falling edge; the bench samples on the rising edge.
// ---------------------------------------------------------------------------
module tb_kfmmc_block_sequencer;

    localparam int BB = 4;
    localparam int AW = 9;
    localparam int TO = 8;
    localparam int PL = 4;

    logic       clock;
    logic       reset;
    logic       start_read;
    logic       start_write;
    logic       abort;
    logic       busy;
    logic       done;
    logic [1:0] error_code;

    kfmmc_block_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    kfmmc_block_sequencer #(
        .BLOCK_BYTES    (BB),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO),
        .BUSY_POLL_LIMIT(PL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_read (start_read),
        .start_write(start_write),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .error_code (error_code),
        .bus        (bus)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    // Stimulus-owned model inputs
    logic [7:0]  rd_mem [0:511];
    logic [7:0]  resp   [0:255];
    logic        hold_busy = 1'b0;
    logic [15:0] crc_s     = 16'h0000;

    // Monitor-owned model state and logs
    logic        model_busy = 1'b0;
    logic        model_rx   = 1'b0;
    logic [7:0]  model_rcv  = 8'h00;
    int          model_cnt  = 0;
    int          ri         = 0;
    int          n_start    = 0;
    int          wr_cnt     = 0;
    int          done_cnt   = 0;
    int          dis_cnt    = 0;
    logic [1:0]  done_code  = 2'd0;
    logic [7:0]  tx_log  [0:255];
    logic        dio_log [0:255];
    logic        chk_log [0:255];
    logic        clr_log [0:255];
    logic [7:0]  wr_mem  [0:511];

    assign bus.data_io_busy  = model_busy;
    assign bus.received_data = model_rcv;
    assign bus.data_crc      = crc_s;

    int n_tests = 0;
    int n_fail  = 0;

    // Engine and buffer model, observing the DUT on the rising edge.
    always @(posedge clock) begin
        bus.buffer_read_data <= rd_mem[bus.buffer_address];
        if (bus.buffer_write) begin
            wr_mem[bus.buffer_address] <= bus.buffer_write_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_code <= error_code;
        end
        if (bus.disable_data_io) dis_cnt <= dis_cnt + 1;
        if (reset || bus.disable_data_io) begin
            model_busy <= 1'b0;
        end else if (bus.start_data_io) begin
            tx_log[n_start & 255]  <= bus.transmit_data;
            dio_log[n_start & 255] <= bus.data_io;
            chk_log[n_start & 255] <= bus.check_data_start_bit;
            clr_log[n_start & 255] <= bus.clear_data_crc;
            n_start    <= n_start + 1;
            model_busy <= 1'b1;
            model_rx   <= bus.data_io;
            model_cnt  <= 1;
        end else if (model_busy && !hold_busy) begin
            if (model_cnt == 0) begin
                model_busy <= 1'b0;
                if (model_rx) begin
                    model_rcv <= resp[ri & 255];
                    ri        <= ri + 1;
                end
            end else begin
                model_cnt <= model_cnt - 1;
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic rd, input logic wr);
        tick();
        start_read  = rd;
        start_write = wr;
        tick();
        start_read  = 1'b0;
        start_write = 1'b0;
    endtask

    task automatic load_resp(input int k, input logic [7:0] b);
        resp[(ri + k) & 255] = b;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 2000; i++) begin
            if (done_cnt != d0) break;
            tick();
        end
        check_value(tag, done_cnt - d0, 1);
    endtask

    task automatic check_reset_state(input string p);
        check_value({p, "_busy"},  {31'd0, busy}, 32'd0);
        check_value({p, "_done"},  {31'd0, done}, 32'd0);
        check_value({p, "_err"},   {30'd0, error_code}, 32'd0);
        check_value({p, "_addr"},  {23'd0, bus.buffer_address}, 32'd0);
        check_value({p, "_bw"},    {31'd0, bus.buffer_write}, 32'd0);
        check_value({p, "_bwd"},   {24'd0, bus.buffer_write_data}, 32'd0);
        check_value({p, "_dis"},   {31'd0, bus.disable_data_io}, 32'd0);
        check_value({p, "_start"}, {31'd0, bus.start_data_io}, 32'd0);
        check_value({p, "_dio"},   {31'd0, bus.data_io}, 32'd1);
        check_value({p, "_chk"},   {31'd0, bus.check_data_start_bit}, 32'd0);
        check_value({p, "_clr"},   {31'd0, bus.clear_data_crc}, 32'd0);
        check_value({p, "_tx"},    {24'd0, bus.transmit_data}, 32'hFF);
    endtask

    initial begin
        #400000;
        $display("FAIL tb_global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, w0, d0, x0, k, sends, polls, stats, chks, clrs;
        logic [7:0] exp_rd [0:3];
        logic [7:0] exp_tx [0:5];
        exp_rd = '{8'hAA, 8'h55, 8'h01, 8'h02};
        exp_tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hBE, 8'hEF};
        for (int i = 0; i < 512; i++) rd_mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) resp[i] = 8'h00;
        reset = 1'b1; start_read = 1'b0; start_write = 1'b0; abort = 1'b0;
        repeat (3) tick();
        check_reset_state("rst");
        reset = 1'b0;
        tick();

        // Good read
        crc_s = 16'h1234;
        for (int i = 0; i < 4; i++) load_resp(i, exp_rd[i]);
        load_resp(4, 8'h12); load_resp(5, 8'h34);
        s0 = n_start; w0 = wr_cnt; d0 = done_cnt;
        do_start(1'b1, 1'b0);
        wait_done("rd_done", d0);
        check_value("rd_code", {30'd0, done_code}, 32'd0);
        for (int i = 0; i < 4; i++) check_value("rd_mem", {24'd0, wr_mem[i]}, {24'd0, exp_rd[i]});
        check_value("rd_writes", wr_cnt - w0, 4);
        check_value("rd_starts", n_start - s0, 6);
        chks = 0; clrs = 0;
        for (int i = s0; i < n_start; i++) begin
            chks += int'(chk_log[i & 255]);
            clrs += int'(clr_log[i & 255]);
        end
        check_value("rd_chk_count", chks, 1);
        check_value("rd_chk_first", {31'd0, chk_log[s0 & 255]}, 32'd1);
        check_value("rd_clr_count", clrs, 1);
        tick();
        check_value("rd_busy_after", {31'd0, busy}, 32'd0);
        check_value("rd_err_held", {30'd0, error_code}, 32'd0);

        // Read with CRC mismatch
        for (int i = 0; i < 4; i++) load_resp(i, exp_rd[i]);
        load_resp(4, 8'h12); load_resp(5, 8'h35);
        w0 = wr_cnt; d0 = done_cnt;
        do_start(1'b1, 1'b0);
        wait_done("crc_done", d0);
        check_value("crc_code", {30'd0, done_code}, 32'd1);
        check_value("crc_writes", wr_cnt - w0, 4);
        tick(); tick();
        check_value("crc_err_held", {30'd0, error_code}, 32'd1);

        // Good write
        rd_mem[0] = 8'h11; rd_mem[1] = 8'h22; rd_mem[2] = 8'h33; rd_mem[3] = 8'h44;
        crc_s = 16'hBEEF;
        load_resp(0, 8'h5F); load_resp(1, 8'h00); load_resp(2, 8'h00); load_resp(3, 8'hFF);
        s0 = n_start; d0 = done_cnt;
        do_start(1'b0, 1'b1);
        wait_done("wr_done", d0);
        check_value("wr_code", {30'd0, done_code}, 32'd0);
        sends = 0; polls = 0; stats = 0; k = 0;
        for (int i = s0; i < n_start; i++) begin
            if (!dio_log[i & 255]) begin
                if (k < 6) check_value("wr_tx", {24'd0, tx_log[i & 255]}, {24'd0, exp_tx[k]});
                k++;
                sends++;
            end else if (chk_log[i & 255]) begin
                stats++;
            end else begin
                polls++;
            end
        end
        check_value("wr_sends", sends, 6);
        check_value("wr_status", stats, 1);
        check_value("wr_polls", polls, 3);
        check_value("wr_clr_first", {31'd0, clr_log[s0 & 255]}, 32'd1);

        // Write rejected by status token
        load_resp(0, 8'hBF);
        s0 = n_start; d0 = done_cnt;
        do_start(1'b0, 1'b1);
        wait_done("rej_done", d0);
        check_value("rej_code", {30'd0, done_code}, 32'd2);
        check_value("rej_starts", n_start - s0, 7);

        // Engine stuck busy: watchdog timeout
        hold_busy = 1'b1;
        x0 = dis_cnt; d0 = done_cnt;
        do_start(1'b1, 1'b0);
        wait_done("to_done", d0);
        check_value("to_code", {30'd0, done_code}, 32'd3);
        check_value("to_disable", dis_cnt - x0, 1);
        tick();
        check_value("to_busy_drop", {31'd0, busy}, 32'd0);
        check_value("to_err_held", {30'd0, error_code}, 32'd3);
        hold_busy = 1'b0;
        tick();

        // Card never releases busy: poll limit
        load_resp(0, 8'h5F);
        for (int i = 1; i <= 5; i++) load_resp(i, 8'h00);
        s0 = n_start; x0 = dis_cnt; d0 = done_cnt;
        do_start(1'b0, 1'b1);
        wait_done("pl_done", d0);
        check_value("pl_code", {30'd0, done_code}, 32'd3);
        check_value("pl_starts", n_start - s0, 11);
        check_value("pl_disable", dis_cnt - x0, 1);

        // Both starts together: read wins
        crc_s = 16'h1234;
        for (int i = 0; i < 4; i++) load_resp(i, exp_rd[i]);
        load_resp(4, 8'h12); load_resp(5, 8'h34);
        s0 = n_start; w0 = wr_cnt; d0 = done_cnt;
        do_start(1'b1, 1'b1);
        wait_done("both_done", d0);
        check_value("both_code", {30'd0, done_code}, 32'd0);
        check_value("both_first_rx", {31'd0, dio_log[s0 & 255]}, 32'd1);
        check_value("both_writes", wr_cnt - w0, 4);

        // Abort mid-block
        for (int i = 0; i < 6; i++) load_resp(i, 8'h77);
        w0 = wr_cnt; d0 = done_cnt; x0 = dis_cnt;
        do_start(1'b1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (wr_cnt - w0 >= 2) break;
            tick();
        end
        check_value("ab_progress", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_value("ab_busy", {31'd0, busy}, 32'd0);
        check_value("ab_disable", {31'd0, bus.disable_data_io}, 32'd1);
        repeat (30) tick();
        check_value("ab_no_done", done_cnt - d0, 0);
        check_value("ab_dis_once", dis_cnt - x0, 1);
        check_value("ab_err", {30'd0, error_code}, 32'd0);

        // Synchronous reset mid-write
        d0 = done_cnt;
        do_start(1'b0, 1'b1);
        repeat (8) tick();
        check_value("rs_active", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        check_reset_state("rs_mid");
        reset = 1'b0;
        repeat (10) tick();
        check_value("rs_no_done", done_cnt - d0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
